// File: rtl/dm_ctrl.sv
// Data-memory controller: host load -> processor run -> host dump -> done.
// Define DM_DUMP_EN to enable the read-back dump phase.
module dm_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              dm_en,
  input  logic [15:0]       dar,
  input  logic [15:0]       bus_in,
  input  logic              end_process,
  output logic [DATA_W-1:0] dm_out,
  output logic [1:0]        status,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_DUMP = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ld_addr;
  logic [ADDR_W-1:0] ra;
  logic              run;
  logic              ld_hs;
  logic              ld_end;
  logic              rd_hs;
  logic              unused_ok;

  assign ra       = dar[ADDR_W-1:0];
  assign run      = (state == S_RUN);
  assign ld_ready = (state == S_LOAD);
  assign status   = state;
  assign ld_hs    = ld_valid & ld_ready;
  assign ld_end   = ld_hs & (ld_last | (&ld_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD: if (ld_end) state_nx = S_RUN;
`ifdef DM_DUMP_EN
      S_RUN:  if (end_process) state_nx = S_DUMP;
`else
      S_RUN:  if (end_process) state_nx = S_DONE;
`endif
      S_DUMP: if (rd_hs && (&dump_addr_q())) state_nx = S_DONE;
      S_DONE: state_nx = S_DONE;
      default: state_nx = S_LOAD;
    endcase
  end

  // RAM is intentionally not reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (ld_hs)
      mem[ld_addr] <= ld_data;
    else if (run && dm_en)
      mem[ra] <= bus_in[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ld_addr <= '0;
    else if (ld_hs) ld_addr <= ld_addr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dm_out <= '0;
    else if (run) dm_out <= mem[ra];
  end

`ifdef DM_DUMP_EN
  typedef enum logic [1:0] {
    P_PRIME   = 2'd0,
    P_FETCH   = 2'd1,
    P_PRESENT = 2'd2
  } phase_t;

  phase_t            ph;
  logic [ADDR_W-1:0] dump_addr;

  function automatic logic [ADDR_W-1:0] dump_addr_q();
    return dump_addr;
  endfunction

  assign rd_hs     = (state == S_DUMP) & rd_valid & rd_ready;
  assign unused_ok = ^{dar[15:ADDR_W], bus_in[15:DATA_W]};

  // One priming cycle after entry, then FETCH/PRESENT per byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_addr <= '0;
      ph        <= P_PRIME;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else if (run && end_process) begin
      dump_addr <= '0;
      ph        <= P_PRIME;
    end else if (state == S_DUMP) begin
      case (ph)
        P_PRIME: ph <= P_FETCH;
        P_FETCH: begin
          rd_data  <= mem[dump_addr];
          rd_valid <= 1'b1;
          ph       <= P_PRESENT;
        end
        P_PRESENT: if (rd_ready) begin
          rd_valid  <= 1'b0;
          dump_addr <= dump_addr + 1'b1;
          ph        <= P_FETCH;
        end
        default: ph <= P_PRIME;
      endcase
    end
  end
`else
  function automatic logic [ADDR_W-1:0] dump_addr_q();
    return '0;
  endfunction

  assign rd_hs     = 1'b0;
  assign rd_valid  = 1'b0;
  assign rd_data   = '0;
  assign unused_ok = ^{dar[15:ADDR_W], bus_in[15:DATA_W], rd_ready};
`endif

endmodule
